// File: rtl/pulse_sched_pkg.sv
// Shared types and default widths for the per-trigger RF pulse scheduler.
// Imported by the scheduler top and its receive output register.
package pulse_sched_pkg;

    localparam int ADDR_W  = 14;
    localparam int RXCNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_TX,
        ST_LAG,
        ST_RX,
        ST_DRAIN
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_sched_if.sv
// AXI-Stream receive path from the pulse scheduler toward the RX DMA.
// The scheduler side is the master; the consumer side is the slave.
interface pulse_sched_if;

    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tlast;
    logic        rx_tready;

    modport master (
        output rx_tdata,
        output rx_tvalid,
        output rx_tlast,
        input  rx_tready
    );

    modport slave (
        input  rx_tdata,
        input  rx_tvalid,
        input  rx_tlast,
        output rx_tready
    );

endinterface

// File: rtl/rx_out_reg.sv
// One-entry AXI-Stream output register for the receive window.
// A sample arriving while a beat is stuck is dropped and flags a sticky overrun.
module rx_out_reg
    import pulse_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          cap_valid,
    input  logic [31:0]   cap_data,
    input  logic          cap_last,
    input  logic          set_last,
    pulse_sched_if.master rx,
    output logic          overrun
);

    logic pop;
    logic hold;

    assign pop  = rx.rx_tvalid && rx.rx_tready;
    // A held beat survives this edge only when the consumer is stalling it.
    assign hold = rx.rx_tvalid && !rx.rx_tready;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx.rx_tdata  <= '0;
            rx.rx_tvalid <= 1'b0;
            rx.rx_tlast  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (cap_valid && !hold) begin
                rx.rx_tdata  <= cap_data;
                rx.rx_tvalid <= 1'b1;
                rx.rx_tlast  <= cap_last;
            end else if (pop) begin
                rx.rx_tvalid <= 1'b0;
                rx.rx_tlast  <= 1'b0;
            end

            // Only tlast may change on a stalled beat, so the stream still terminates.
            if (hold && (set_last || (cap_valid && cap_last))) begin
                rx.rx_tlast <= 1'b1;
            end

            if (hold && cap_valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// Per-trigger pulse scheduler: PA lead, DAC playback, PA lag, then an ADC
// receive window streamed out over AXI-Stream. FSM and counters live here.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int ADDR_W  = pulse_sched_pkg::ADDR_W,
    parameter int RXCNT_W = pulse_sched_pkg::RXCNT_W,
    parameter int PA_LEAD = 8,
    parameter int PA_LAG  = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic               trig,
    input  logic [ADDR_W-1:0]  txsmps,
    input  logic [RXCNT_W-1:0] rxsmps,
    input  logic [31:0]        adc_0,
    output logic [ADDR_W-1:0]  dac_0_addr,
    output logic               pa_en,
    pulse_sched_if.master      rx,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic [15:0]        trig_miss
);

    localparam int CNT_W = max_int(max_int(ADDR_W, RXCNT_W),
                                   $clog2(max_int(PA_LEAD, PA_LAG) + 1));

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  tx_len_q;
    logic [RXCNT_W-1:0] rx_len_q;
    logic               done_q, done_d;
    logic [15:0]        miss_q;

    logic run_state;
    logic abort;
    logic accept;
    logic lead_last;
    logic tx_last;
    logic lag_last;
    logic rx_last;
    logic drain_empty;

    assign run_state = (state_q == ST_LEAD) || (state_q == ST_TX) ||
                       (state_q == ST_LAG)  || (state_q == ST_RX);
    assign abort     = run_state && !enable;
    // A trigger landing on the done cycle is treated as a miss.
    assign accept    = (state_q == ST_IDLE) && !done_q && trig && enable;

    assign lead_last = (cnt_q == CNT_W'(PA_LEAD - 1));
    assign tx_last   = (cnt_q == CNT_W'(tx_len_q) - CNT_W'(1));
    assign lag_last  = (cnt_q == CNT_W'(PA_LAG - 1));
    assign rx_last   = (cnt_q == CNT_W'(rx_len_q) - CNT_W'(1));
    // Leave DRAIN on the cycle the last beat is handshaked, so done follows it directly.
    assign drain_empty = !rx.rx_tvalid || rx.rx_tready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (txsmps != '0)      state_d = ST_LEAD;
                    else if (rxsmps != '0) state_d = ST_RX;
                end
            end
            ST_LEAD: begin
                if (abort)          state_d = ST_DRAIN;
                else if (lead_last) state_d = ST_TX;
            end
            ST_TX: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else if (tx_last) begin
                    if (PA_LAG > 0)          state_d = ST_LAG;
                    else if (rx_len_q != '0) state_d = ST_RX;
                    else                     state_d = ST_IDLE;
                end
            end
            ST_LAG: begin
                if (abort)         state_d = ST_DRAIN;
                else if (lag_last) state_d = (rx_len_q != '0) ? ST_RX : ST_IDLE;
            end
            ST_RX: begin
                if (abort || rx_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = (run_state && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
        done_d = ((state_q != ST_IDLE) && (state_d == ST_IDLE)) ||
                 (accept && (txsmps == '0) && (rxsmps == '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            tx_len_q <= '0;
            rx_len_q <= '0;
            miss_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (accept) begin
                tx_len_q <= txsmps;
                rx_len_q <= rxsmps;
            end
            if (trig && !accept && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign pa_en      = (state_q == ST_LEAD) || (state_q == ST_TX) || (state_q == ST_LAG);
    assign dac_0_addr = (state_q == ST_TX) ? cnt_q[ADDR_W-1:0] : '0;
    assign done       = done_q;
    assign trig_miss  = miss_q;

    rx_out_reg u_rx_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .cap_valid ((state_q == ST_RX) && enable),
        .cap_data  (adc_0),
        .cap_last  (rx_last),
        .set_last  (abort),
        .rx        (rx),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_pulse_sched.sv
// Self-checking bench for pulse_sched: directed scenarios plus randomized traffic,
// checked each cycle against a timeline/queue reference model.
module tb_pulse_sched;

    localparam int ADDR_W  = 14;
    localparam int RXCNT_W = 16;
    localparam int PA_LEAD = 8;
    localparam int PA_LAG  = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               enable = 1'b0;
    logic               trig = 1'b0;
    logic [ADDR_W-1:0]  txsmps = '0;
    logic [RXCNT_W-1:0] rxsmps = '0;
    logic [31:0]        adc_0 = '0;
    logic [ADDR_W-1:0]  dac_0_addr;
    logic               pa_en;
    logic               busy;
    logic               done;
    logic               overrun;
    logic [15:0]        trig_miss;

    pulse_sched_if rx_if ();

    pulse_sched #(
        .ADDR_W  (ADDR_W),
        .RXCNT_W (RXCNT_W),
        .PA_LEAD (PA_LEAD),
        .PA_LAG  (PA_LAG)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .trig       (trig),
        .txsmps     (txsmps),
        .rxsmps     (rxsmps),
        .adc_0      (adc_0),
        .dac_0_addr (dac_0_addr),
        .pa_en      (pa_en),
        .rx         (rx_if),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .trig_miss  (trig_miss)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    // Reference model: period timeline relative to the accepting cycle, plus a
    // capacity-one queue standing in for the output register.
    beat_t q[$];
    int    cyc = 0;
    bit    m_active, m_done, m_aborted;
    int    m_n0, m_T, m_R, m_rs, m_endp, m_abort_cyc;
    int    m_miss;
    bit    m_ovr;

    int n_checks = 0;
    int n_errors = 0;
    bit rnd_mode = 0;
    int beats, done_cnt, pa_cnt;
    bit last_tlast;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_done = 0; m_aborted = 0;
        m_n0 = 0; m_T = 0; m_R = 0; m_rs = 0; m_endp = 0; m_abort_cyc = 0;
        m_miss = 0; m_ovr = 0;
    endtask

    task automatic model_update();
        int    rel;
        bit    end_now, acc;
        beat_t b;
        rel = cyc - m_n0;
        end_now = 0;
        if (q.size() > 0 && rx_if.rx_tready) b = q.pop_front();
        if (m_active && !m_aborted && rel >= 1 && rel <= m_endp) begin
            if (!enable) begin
                m_aborted = 1;
                m_abort_cyc = cyc;
                if (q.size() > 0) begin b = q[0]; b.last = 1'b1; q[0] = b; end
            end else if (m_R > 0 && rel >= m_rs) begin
                b.data = adc_0;
                b.last = (rel == m_endp);
                if (q.size() == 0) begin
                    q.push_back(b);
                end else begin
                    m_ovr = 1;
                    if (b.last) begin b = q[0]; b.last = 1'b1; q[0] = b; end
                end
            end
            if (!m_aborted && m_R == 0 && rel == m_endp) end_now = 1;
        end else if (m_active) begin
            if ((m_aborted || (m_R > 0 && rel > m_endp)) && q.size() == 0) end_now = 1;
        end
        acc = !m_active && !m_done && trig && enable;
        if (trig && !acc && m_miss < 65535) m_miss++;
        m_done = end_now;
        if (end_now) m_active = 0;
        if (acc) begin
            m_T = int'(txsmps);
            m_R = int'(rxsmps);
            m_rs = (m_T > 0) ? PA_LEAD + m_T + PA_LAG + 1 : 1;
            m_endp = (m_R > 0) ? m_rs + m_R - 1 : ((m_T > 0) ? PA_LEAD + m_T + PA_LAG : 0);
            if (m_T == 0 && m_R == 0) begin
                m_done = 1;
            end else begin
                m_active = 1;
                m_n0 = cyc;
                m_aborted = 0;
            end
        end
        cyc++;
    endtask

    task automatic check_outputs();
        int rel, addr_e;
        bit run, pa_e;
        rel = cyc - m_n0;
        run = m_active && !m_aborted && rel >= 1 && rel <= m_endp;
        pa_e = run && m_T > 0 && rel <= PA_LEAD + m_T + PA_LAG;
        addr_e = (run && m_T > 0 && rel >= PA_LEAD + 1 && rel <= PA_LEAD + m_T) ? rel - PA_LEAD - 1 : 0;
        check("pa_en", 64'(pa_en), 64'(pa_e));
        check("dac_0_addr", 64'(dac_0_addr), 64'(addr_e));
        check("busy", 64'(busy), 64'(m_active));
        check("done", 64'(done), 64'(m_done));
        check("rx_tvalid", 64'(rx_if.rx_tvalid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check("rx_tdata", 64'(rx_if.rx_tdata), 64'(q[0].data));
            check("rx_tlast", 64'(rx_if.rx_tlast), 64'(q[0].last));
        end else begin
            check("rx_tlast_idle", 64'(rx_if.rx_tlast), 64'(0));
        end
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("trig_miss", 64'(trig_miss), 64'(m_miss));
    endtask

    task automatic tick();
        if (rx_if.rx_tvalid && rx_if.rx_tready) begin
            beats++;
            last_tlast = rx_if.rx_tlast;
        end
        if (done)  done_cnt++;
        if (pa_en) pa_cnt++;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
        adc_0 = $urandom();
        if (rnd_mode) begin
            rx_if.rx_tready = ($urandom_range(0, 3) != 0);
            trig   = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 79) != 0);
            txsmps = ADDR_W'($urandom_range(0, 12));
            rxsmps = RXCNT_W'($urandom_range(0, 16));
        end
    endtask

    task automatic clear_stats();
        beats = 0; done_cnt = 0; pa_cnt = 0; last_tlast = 0;
    endtask

    task automatic start(input int t, input int r);
        txsmps = ADDR_W'(t);
        rxsmps = RXCNT_W'(r);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        // Length changes mid-period must be ignored by the scheduler.
        txsmps = ADDR_W'(3);
        rxsmps = RXCNT_W'(1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((m_active || m_done) && k < budget) begin
            tick();
            k++;
        end
        check("idle_reached", 64'(busy), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int miss_before;
        model_reset();
        rx_if.rx_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs();
        check("rst_tdata", 64'(rx_if.rx_tdata), 64'(0));
        rstn = 1'b1;
        enable = 1'b1;
        tick();

        // Nominal period.
        clear_stats();
        start(16, 32);
        wait_idle(200);
        check("nom_beats", 64'(beats), 64'(32));
        check("nom_tlast", 64'(last_tlast), 64'(1));
        check("nom_done_cnt", 64'(done_cnt), 64'(1));
        check("nom_pa_cycles", 64'(pa_cnt), 64'(28));
        check("nom_overrun", 64'(overrun), 64'(0));

        // Backpressure mid-window.
        clear_stats();
        start(4, 32);
        k = 0;
        while (beats < 10 && k < 200) begin tick(); k++; end
        check("bp_reach", 64'(beats >= 10), 64'(1));
        rx_if.rx_tready = 1'b0;
        repeat (5) tick();
        rx_if.rx_tready = 1'b1;
        wait_idle(200);
        check("bp_beats", 64'(beats), 64'(27));
        check("bp_tlast", 64'(last_tlast), 64'(1));
        check("bp_overrun", 64'(overrun), 64'(1));

        // Zero lengths.
        clear_stats();
        start(0, 4);
        wait_idle(100);
        check("rxonly_beats", 64'(beats), 64'(4));
        check("rxonly_pa", 64'(pa_cnt), 64'(0));
        clear_stats();
        start(0, 0);
        check("zero_done", 64'(done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        wait_idle(20);
        check("zero_beats", 64'(beats), 64'(0));

        // Missed triggers.
        clear_stats();
        miss_before = m_miss;
        start(16, 4);
        repeat (10) tick();
        repeat (3) begin
            trig = 1'b1; tick();
            trig = 1'b0; tick();
        end
        wait_idle(200);
        enable = 1'b0; trig = 1'b1; tick();
        enable = 1'b1; trig = 1'b0; tick();
        check("miss_count", 64'(trig_miss), 64'(miss_before + 4));
        check("miss_beats", 64'(beats), 64'(4));
        check("miss_pa", 64'(pa_cnt), 64'(28));

        // Abort on the 5th TX cycle.
        clear_stats();
        start(16, 8);
        repeat (PA_LEAD + 4) tick();
        check("abort_addr_pre", 64'(dac_0_addr), 64'(4));
        enable = 1'b0;
        tick();
        check("abort_pa", 64'(pa_en), 64'(0));
        check("abort_addr", 64'(dac_0_addr), 64'(0));
        enable = 1'b1;
        wait_idle(50);
        check("abort_beats", 64'(beats), 64'(0));
        check("abort_done_cnt", 64'(done_cnt), 64'(1));

        // Asynchronous reset in the middle of RX.
        start(2, 20);
        repeat (PA_LEAD + 2 + PA_LAG + 5) tick();
        #2 rstn = 1'b0;
        #1;
        check("arst_pa", 64'(pa_en), 64'(0));
        check("arst_addr", 64'(dac_0_addr), 64'(0));
        check("arst_tvalid", 64'(rx_if.rx_tvalid), 64'(0));
        check("arst_tlast", 64'(rx_if.rx_tlast), 64'(0));
        check("arst_tdata", 64'(rx_if.rx_tdata), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_done", 64'(done), 64'(0));
        check("arst_overrun", 64'(overrun), 64'(0));
        check("arst_miss", 64'(trig_miss), 64'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        clear_stats();
        start(16, 32);
        wait_idle(200);
        check("post_rst_beats", 64'(beats), 64'(32));
        check("post_rst_done", 64'(done_cnt), 64'(1));

        // Randomized traffic.
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;
        trig = 1'b0;
        enable = 1'b1;
        rx_if.rx_tready = 1'b1;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
